// File: rtl/shift_pkg.sv
// Shared types for the shift issue stage: funct3 codes, skid FSM states, shifter micro-op.
package shift_pkg;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  // Tag width of the micro-op; the stage's TAG_W parameter must match it.
  localparam int SHIFT_TAG_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]            data;
    logic [4:0]             shift;
    logic                   left;
    logic                   arith;
    logic [SHIFT_TAG_W-1:0] rd;
    logic                   illegal;
  } shift_uop_t;

endpackage

// File: rtl/shift_uop_decode.sv
// Combinational decode of an RV32 shift op into shifter operands.
// Zero latency; no flow control of its own.
module shift_uop_decode
  import shift_pkg::*;
#(
  parameter int TAG_W = SHIFT_TAG_W
) (
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic             in_is_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [4:0]       in_imm_shamt,
  input  logic [TAG_W-1:0] in_rd,
  output shift_uop_t       uop
);

  logic is_left;
  logic is_right;
  // RV32 shifts only look at rs2[4:0]; the upper bits are deliberately dropped.
  logic unused_rs2_hi;

  assign unused_rs2_hi = ^in_rs2[31:5];
  assign is_left  = (in_funct3 == FUNCT3_SLL) && !in_funct7_5;
  assign is_right = (in_funct3 == FUNCT3_SR);

  always_comb begin
    uop         = '0;
    uop.data    = in_rs1;
    uop.shift   = in_is_imm ? in_imm_shamt : in_rs2[4:0];
    uop.left    = is_left;
    uop.arith   = is_right && in_funct7_5;
    uop.rd      = in_rd;
    uop.illegal = !(is_left || is_right);
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decode, then 2-entry skid buffer with registered in_ready; 1-cycle latency.
// Optional SHIFT_ISSUE_PERF_EN adds perf_issued/perf_stall counters.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int TAG_W = SHIFT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic             in_is_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [4:0]       in_imm_shamt,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_shift,
  output logic             out_shift_left,
  output logic             out_arith,
  output logic [TAG_W-1:0] out_rd,
`ifdef SHIFT_ISSUE_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
`endif
  output logic             out_illegal
);

  shift_uop_t dec_uop;
  shift_uop_t out_q;
  shift_uop_t skid_q;
  state_t     state;
  logic       accept;
  logic       drain;

  shift_uop_decode #(.TAG_W(TAG_W)) u_decode (
    .in_funct3    (in_funct3),
    .in_funct7_5  (in_funct7_5),
    .in_is_imm    (in_is_imm),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm_shamt (in_imm_shamt),
    .in_rd        (in_rd),
    .uop          (dec_uop)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // in_ready is registered as "next state is not TWO", so it never depends on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_q     <= dec_uop;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_q   <= dec_uop;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (drain && !accept) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (drain && accept) begin
            out_q <= dec_uop;
          end
        end
        TWO: begin
          if (drain) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  assign out_data       = out_q.data;
  assign out_shift      = out_q.shift;
  assign out_shift_left = out_q.left;
  assign out_arith      = out_q.arith;
  assign out_rd         = out_q.rd;
  assign out_illegal    = out_q.illegal;

`ifdef SHIFT_ISSUE_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid && out_ready)  perf_issued <= perf_issued + 32'd1;
      if (out_valid && !out_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed scenarios plus random traffic against a queue model.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_imm_shamt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_shift;
  logic        out_shift_left;
  logic        out_arith;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_funct3      (in_funct3),
    .in_funct7_5    (in_funct7_5),
    .in_is_imm      (in_is_imm),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm_shamt   (in_imm_shamt),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_shift      (out_shift),
    .out_shift_left (out_shift_left),
    .out_arith      (out_arith),
    .out_rd         (out_rd),
`ifdef SHIFT_ISSUE_PERF_EN
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall),
`endif
    .out_illegal    (out_illegal)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shift;
    logic        left;
    logic        arith;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          ready_ok = 0;
  bit          last_acc = 0;
  logic [31:0] perf_iss_m = 0;
  logic [31:0] perf_st_m = 0;

  function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [4:0] sh, input logic [4:0] rd);
    exp_t e;
    bit is_sll = (f3 == 3'd1) && !f7;
    bit is_sr  = (f3 == 3'd5);
    e.data    = rs1;
    e.shift   = imm ? sh : rs2[4:0];
    e.illegal = !(is_sll || is_sr);
    e.left    = is_sll;
    e.arith   = is_sr && f7;
    e.rd      = rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return ready_ok && (q.size() < 2);
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_shift", {27'd0, out_shift}, {27'd0, q[0].shift});
      chk("out_shift_left", {31'd0, out_shift_left}, {31'd0, q[0].left});
      chk("out_arith", {31'd0, out_arith}, {31'd0, q[0].arith});
      chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].illegal});
    end
`ifdef SHIFT_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, perf_iss_m);
    chk("perf_stall", perf_stall, perf_st_m);
`endif
  endtask

  // Inputs are set at a negedge; this advances one clock, updates the model, checks at the next negedge.
  task automatic cycle();
    bit acc = in_valid && exp_ready();
    bit drn = (q.size() > 0) && out_ready;
    bit stl = (q.size() > 0) && !out_ready;
    exp_t e = model(in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm_shamt, in_rd);
    @(posedge clk);
    if (drn) perf_iss_m++;
    if (stl) perf_st_m++;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    ready_ok = 1;
    last_acc = acc && !flush;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_op(input logic [2:0] f3, input logic f7, input logic imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] sh, input logic [4:0] rd);
    in_funct3 = f3; in_funct7_5 = f7; in_is_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_imm_shamt = sh; in_rd = rd;
  endtask

  task automatic rand_op();
    logic [2:0] f3;
    case ($urandom_range(0, 3))
      0, 1:    f3 = 3'd1;
      2:       f3 = 3'd5;
      default: f3 = 3'($urandom);
    endcase
    set_op(f3, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);

    // Reset state
    @(negedge clk);
    check_outputs();
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // SRAI
    set_op(3'd5, 1'b1, 1'b1, 32'h8000_00F0, 32'h0000_001F, 5'd4, 5'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("srai_valid", {31'd0, out_valid}, 32'd1);
    chk("srai_data", out_data, 32'h8000_00F0);
    chk("srai_shift", {27'd0, out_shift}, 32'd4);
    chk("srai_left", {31'd0, out_shift_left}, 32'd0);
    chk("srai_arith", {31'd0, out_arith}, 32'd1);
    chk("srai_illegal", {31'd0, out_illegal}, 32'd0);

    // SLL with upper rs2 bits set
    set_op(3'd1, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 5'd9, 5'd2);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("sll_shift", {27'd0, out_shift}, 32'd3);
    chk("sll_left", {31'd0, out_shift_left}, 32'd1);

    // Illegal funct3=001 with f7_5=1
    set_op(3'd1, 1'b1, 1'b1, 32'h1234_5678, 32'd0, 5'd5, 5'd3);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_left", {31'd0, out_shift_left}, 32'd0);
    chk("ill_arith", {31'd0, out_arith}, 32'd0);
    chk("ill_data", out_data, 32'h1234_5678);
    cycle();

    // A,B,C back-to-back with two stalled cycles
    out_ready = 1'b0;
    set_op(3'd1, 1'b0, 1'b1, 32'h1111_0001, 32'd0, 5'd1, 5'd10);
    in_valid = 1'b1;
    cycle();
    set_op(3'd5, 1'b0, 1'b1, 32'h2222_0002, 32'd0, 5'd2, 5'd11);
    cycle();
    chk("ready_drop_after_b", {31'd0, in_ready}, 32'd0);
    chk("a_stable_1", out_data, 32'h1111_0001);
    set_op(3'd5, 1'b1, 1'b1, 32'h3333_0003, 32'd0, 5'd3, 5'd12);
    cycle();
    chk("a_stable_2", out_data, 32'h1111_0001);
    out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 8 && !last_acc; i++) cycle();
    chk("c_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Flush while TWO with in_valid high
    out_ready = 1'b0; in_valid = 1'b1;
    rand_op(); cycle();
    rand_op(); cycle();
    rand_op(); flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_two_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_two_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cycle();

    // Flush in ONE drops the same-cycle accept
    in_valid = 1'b1; out_ready = 1'b0;
    rand_op(); cycle();
    rand_op(); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_valid", {31'd0, out_valid}, 32'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;

    // Async reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0;
    rand_op(); cycle();
    rand_op(); cycle();
    #2 rst = 1'b1;
    #1;
    q.delete(); ready_ok = 0; perf_iss_m = 0; perf_st_m = 0;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_data", out_data, 32'd0);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("arst_perf_issued", perf_issued, 32'd0);
    chk("arst_perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check_outputs();
    rst = 1'b0;
    cycle();

    // Ten drains at full throughput
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_op();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("drained_10", {31'd0, out_valid}, 32'd0);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("perf_issued_10", perf_issued, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
